switch_alloc6: RTL and testbench
================================

SWITCH_ALLOC6 -- requirements
Module: switch_alloc6

Interface
REQ-001 SHALL have parameter NUM_PORT, default 6, number of router ports; index 0 = bypass, indices 1..5 = ports 0..4.
REQ-002 SHALL have parameter LOG_NUM_PORT, default 3, width of one port index.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port reqValid  input  NUM_PORT  per-input request valid.
REQ-006 SHALL have port reqPort  input  NUM_PORT*LOG_NUM_PORT  requested output of input i in bits [i*3+:3].
REQ-007 SHALL have port reqTail  input  NUM_PORT  per-input flag: the requesting flit is a packet tail.
REQ-008 SHALL have port outReady  input  NUM_PORT  per-output flag: downstream can accept a flit this cycle.
REQ-009 SHALL have port grant  output  NUM_PORT  registered per-input grant.
REQ-010 SHALL have port allocVector  output  NUM_PORT*NUM_PORT  registered; bit [i*NUM_PORT+j] = input i connected to output j; drives the 6-port crossbar control.
REQ-011 SHALL have port allocValid  output  1  registered; high when any bit of allocVector is set.

Function
REQ-012 SHALL sample requests on clk edge N and present grant/allocVector/allocValid from edge N+1 for exactly one cycle (latency 1, no stall path).
REQ-013 SHALL ignore any request with reqPort >= NUM_PORT (no grant, no state change).
REQ-014 SHALL arbitrate each output j independently with a round-robin pointer rrPtr[j] (3 bits, 0..5); the eligible input with the lowest index at or after rrPtr[j], wrapping 5->0, wins.
REQ-015 SHALL grant output j only when outReady[j] is high; if low, no grant to j and rrPtr[j] and lock state of j unchanged.
REQ-016 SHALL on a grant of input k to output j set rrPtr[j] to (k+1) mod 6, wrapping 5->0.
REQ-017 SHALL guarantee allocVector has at most one set bit per row (input) and per column (output); grant[i] = OR of row i.
REQ-018 SHALL keep all unrequested outputs' pointers unchanged.
REQ-019 SHALL, with ALLOC_LOCK_EN, run per-output state machine IDLE/LOCKED: IDLE->LOCKED on a grant with reqTail low, recording owner k; LOCKED->IDLE on a grant to owner with reqTail high; otherwise hold.
REQ-020 SHALL in LOCKED grant output j only to its owner; other requesters blocked; owner with reqValid low or ready low retains lock with no grant.
REQ-021 SHALL in LOCKED not advance rrPtr[j] on owner non-tail grants; advance per REQ-016 on the tail grant.
REQ-022 SHALL treat a single-flit packet (reqTail high on IDLE grant) as grant without entering LOCKED.

Reset
REQ-023 SHALL on reset high, asynchronously clear grant, allocVector, allocValid to 0, all rrPtr to 0, all outputs to IDLE with owner 0.
REQ-024 SHALL on reset mid-packet drop any lock; first edge after reset deassertion arbitrates from fresh state.

Configuration
REQ-025 SHALL compile the lock logic of REQ-019..REQ-022 only when macro ALLOC_LOCK_EN is defined.
REQ-026 SHALL without ALLOC_LOCK_EN arbitrate every flit independently per REQ-014..REQ-016, ignore reqTail, and contain no lock state.

Verification
REQ-027 SHALL cover: reset, then inputs 1 and 3 request output 2, outReady=all 1 -> next cycle allocVector bit 1*6+2 set, grant=6'b000010, rrPtr[2]=2; repeat -> input 3 wins (bit 20).
REQ-028 SHALL cover: rrPtr[4]=5, inputs 0 and 5 request output 4 -> input 5 wins, rrPtr[4] wraps to 0; repeat -> input 0 wins.
REQ-029 SHALL cover: input 2 requests output 0 with reqPort=7 or outReady[0]=0 -> grant=0, allocValid=0, pointer unchanged.
REQ-030 SHALL cover (ALLOC_LOCK_EN): input 1 head flit to output 3 granted, input 4 also requests output 3 for 3 cycles -> only input 1 granted until its tail; cycle after tail, input 4 granted.
REQ-031 SHALL cover: all six inputs request distinct outputs with outReady all 1 -> six grants in one cycle, allocVector one-hot per row/column, allocValid=1.
REQ-032 SHALL cover: reset asserted while output 3 LOCKED -> outputs zero asynchronously; after release input 4 wins output 3 without waiting for a tail.

Source files
------------

// File: rtl/switch_alloc6_if.sv
// Request/grant bundle between the router input stage and the switch allocator,
// with read-only views of the allocator's arbitration state.
interface switch_alloc6_if #(
  parameter int NUM_PORT     = 6,
  parameter int LOG_NUM_PORT = 3
);
  // No handshake stall: a request held high on edge N receives its grant
  // from edge N+1 for one cycle; a grant is valid only while outReady of
  // the granted output was high on edge N.
  logic [NUM_PORT-1:0]              reqValid;
  logic [NUM_PORT*LOG_NUM_PORT-1:0] reqPort;
  logic [NUM_PORT-1:0]              reqTail;
  logic [NUM_PORT-1:0]              outReady;
  logic [NUM_PORT-1:0]              grant;
  logic [NUM_PORT*NUM_PORT-1:0]     allocVector;
  logic                             allocValid;
  logic [NUM_PORT*LOG_NUM_PORT-1:0] dbgRrPtr;
  logic [NUM_PORT-1:0]              dbgLocked;

  modport master (
    output reqValid, reqPort, reqTail, outReady,
    input  grant, allocVector, allocValid, dbgRrPtr, dbgLocked
  );

  modport slave (
    input  reqValid, reqPort, reqTail, outReady,
    output grant, allocVector, allocValid, dbgRrPtr, dbgLocked
  );
endinterface

// File: rtl/switch_alloc6.sv
// Per-output round-robin switch allocator with registered grants.
// Define ALLOC_LOCK_EN to hold an output for a multi-flit packet until its tail.
module switch_alloc6 #(
  parameter int NUM_PORT     = 6,
  parameter int LOG_NUM_PORT = 3
) (
  input  logic            clk,
  input  logic            reset,
  switch_alloc6_if.slave  bus
);
  localparam int NP = NUM_PORT;
  localparam int LP = LOG_NUM_PORT;

  logic [NP*NP-1:0]        alloc_q, alloc_d;
  logic [NP-1:0]           grant_q, grant_d;
  logic                    valid_q, valid_d;
  logic [NP-1:0][LP-1:0]   rr_q, rr_d;
  logic [NP-1:0][NP-1:0]   elig;

`ifdef ALLOC_LOCK_EN
  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} lock_state_e;
  lock_state_e           state_q [NP];
  lock_state_e           state_d [NP];
  logic [NP-1:0][LP-1:0] owner_q, owner_d;
`endif

  // elig[i][j]: input i may compete for output j this cycle. Out-of-range
  // port numbers never match any j, so they are silently dropped.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NP; i++) begin
      for (int j = 0; j < NP; j++) begin
        elig[i][j] = bus.reqValid[i] && (bus.reqPort[i*LP +: LP] == LP'(j));
`ifdef ALLOC_LOCK_EN
        if (state_q[j] == LOCKED && owner_q[j] != LP'(i)) elig[i][j] = 1'b0;
`endif
      end
    end
  end

  always_comb begin
    alloc_d = '0;
    rr_d    = rr_q;
`ifdef ALLOC_LOCK_EN
    state_d = state_q;
    owner_d = owner_q;
`endif
    for (int j = 0; j < NP; j++) begin
      logic found;
      int   win;
      int   idx;
      found = 1'b0;
      win   = 0;
      idx   = 0;
      for (int off = 0; off < NP; off++) begin
        idx = int'(rr_q[j]) + off;
        if (idx >= NP) idx = idx - NP;
        if (!found && elig[idx][j]) begin
          found = 1'b1;
          win   = idx;
        end
      end
      if (found && bus.outReady[j]) begin
        alloc_d[win*NP + j] = 1'b1;
`ifdef ALLOC_LOCK_EN
        // The pointer only moves when a packet ends or on a fresh IDLE grant.
        if (state_q[j] == LOCKED) begin
          if (bus.reqTail[win]) begin
            state_d[j] = IDLE;
            rr_d[j]    = LP'((win + 1) % NP);
          end
        end else begin
          rr_d[j] = LP'((win + 1) % NP);
          if (!bus.reqTail[win]) begin
            state_d[j] = LOCKED;
            owner_d[j] = LP'(win);
          end
        end
`else
        rr_d[j] = LP'((win + 1) % NP);
`endif
      end
    end
  end

  always_comb begin
    grant_d = '0;
    for (int i = 0; i < NP; i++) grant_d[i] = |alloc_d[i*NP +: NP];
    valid_d = |alloc_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alloc_q <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
      rr_q    <= '0;
    end else begin
      alloc_q <= alloc_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      rr_q    <= rr_d;
    end
  end

`ifdef ALLOC_LOCK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < NP; j++) state_q[j] <= IDLE;
      owner_q <= '0;
    end else begin
      for (int j = 0; j < NP; j++) state_q[j] <= state_d[j];
      owner_q <= owner_d;
    end
  end

  always_comb begin
    bus.dbgLocked = '0;
    for (int j = 0; j < NP; j++) bus.dbgLocked[j] = (state_q[j] == LOCKED);
  end
`else
  // Tail flags only matter for packet locking.
  logic unused_tail;
  assign unused_tail   = ^bus.reqTail;
  assign bus.dbgLocked = '0;
`endif

  assign bus.grant       = grant_q;
  assign bus.allocVector = alloc_q;
  assign bus.allocValid  = valid_q;
  assign bus.dbgRrPtr    = rr_q;
endmodule

// File: tb/tb_switch_alloc6.sv
// Directed bench for switch_alloc6; lock scenarios run when ALLOC_LOCK_EN is defined.
module tb_switch_alloc6;
  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  switch_alloc6_if #(.NUM_PORT(6), .LOG_NUM_PORT(3)) bus ();

  switch_alloc6 #(.NUM_PORT(6), .LOG_NUM_PORT(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic clear_req();
    bus.reqValid = '0;
    bus.reqPort  = '0;
    bus.reqTail  = '0;
  endtask

  task automatic set_req(input int i, input int port, input logic tail);
    logic [2:0] p;
    p = 3'(port);
    bus.reqValid[i]       = 1'b1;
    bus.reqPort[i*3 +: 3] = p;
    bus.reqTail[i]        = tail;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_req();
    bus.outReady = '1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  function automatic logic [2:0] rr(input int j);
    return bus.dbgRrPtr[j*3 +: 3];
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    tests_run++;
    if (bus.grant !== 6'b0) begin
      tests_failed++; $display("FAIL reset_grant: got %b want %b", bus.grant, 6'b0);
    end
    tests_run++;
    if (bus.allocVector !== 36'b0) begin
      tests_failed++; $display("FAIL reset_alloc: got %h want %h", bus.allocVector, 36'h0);
    end
    tests_run++;
    if (bus.allocValid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_valid: got %b want 0", bus.allocValid);
    end
    tests_run++;
    if (bus.dbgRrPtr !== 18'b0 || bus.dbgLocked !== 6'b0) begin
      tests_failed++; $display("FAIL reset_state: rr %h lock %b want 0 0", bus.dbgRrPtr, bus.dbgLocked);
    end
  endtask

  task automatic test_round_robin();
    logic [35:0] exp;
    do_reset();
    set_req(1, 2, 1'b1);
    set_req(3, 2, 1'b1);
    step();
    exp = '0; exp[1*6+2] = 1'b1;
    tests_run++;
    if (bus.allocVector !== exp || bus.grant !== 6'b000010) begin
      tests_failed++; $display("FAIL rr_first: alloc %h grant %b want %h %b", bus.allocVector, bus.grant, exp, 6'b000010);
    end
    tests_run++;
    if (rr(2) !== 3'd2) begin
      tests_failed++; $display("FAIL rr_ptr2_a: got %0d want 2", rr(2));
    end
    step();
    exp = '0; exp[20] = 1'b1;
    tests_run++;
    if (bus.allocVector !== exp || bus.grant !== 6'b001000) begin
      tests_failed++; $display("FAIL rr_second: alloc %h grant %b want %h %b", bus.allocVector, bus.grant, exp, 6'b001000);
    end
    tests_run++;
    if (rr(2) !== 3'd4) begin
      tests_failed++; $display("FAIL rr_ptr2_b: got %0d want 4", rr(2));
    end
    clear_req();
    step();
    tests_run++;
    if (bus.grant !== 6'b0 || bus.allocValid !== 1'b0) begin
      tests_failed++; $display("FAIL one_cycle: grant %b valid %b want 0 0", bus.grant, bus.allocValid);
    end
  endtask

  task automatic test_wrap();
    logic [35:0] exp;
    do_reset();
    set_req(4, 4, 1'b1);
    step();
    tests_run++;
    if (rr(4) !== 3'd5) begin
      tests_failed++; $display("FAIL wrap_setup: got %0d want 5", rr(4));
    end
    clear_req();
    set_req(0, 4, 1'b1);
    set_req(5, 4, 1'b1);
    step();
    exp = '0; exp[5*6+4] = 1'b1;
    tests_run++;
    if (bus.allocVector !== exp || rr(4) !== 3'd0) begin
      tests_failed++; $display("FAIL wrap_in5: alloc %h rr %0d want %h 0", bus.allocVector, rr(4), exp);
    end
    step();
    exp = '0; exp[4] = 1'b1;
    tests_run++;
    if (bus.allocVector !== exp || bus.grant !== 6'b000001 || rr(4) !== 3'd1) begin
      tests_failed++; $display("FAIL wrap_in0: alloc %h grant %b rr %0d want %h 000001 1", bus.allocVector, bus.grant, rr(4), exp);
    end
    clear_req();
  endtask

  task automatic test_blocked();
    logic [35:0] exp;
    do_reset();
    set_req(2, 7, 1'b1);
    step();
    tests_run++;
    if (bus.grant !== 6'b0 || bus.allocValid !== 1'b0 || bus.dbgRrPtr !== 18'b0) begin
      tests_failed++; $display("FAIL bad_port: grant %b valid %b rr %h want 0 0 0", bus.grant, bus.allocValid, bus.dbgRrPtr);
    end
    set_req(2, 0, 1'b1);
    bus.outReady[0] = 1'b0;
    step();
    tests_run++;
    if (bus.grant !== 6'b0 || bus.allocValid !== 1'b0 || rr(0) !== 3'd0) begin
      tests_failed++; $display("FAIL not_ready: grant %b valid %b rr %0d want 0 0 0", bus.grant, bus.allocValid, rr(0));
    end
    bus.outReady[0] = 1'b1;
    step();
    exp = '0; exp[2*6+0] = 1'b1;
    tests_run++;
    if (bus.allocVector !== exp || bus.allocValid !== 1'b1 || rr(0) !== 3'd3) begin
      tests_failed++; $display("FAIL ready_again: alloc %h valid %b rr %0d want %h 1 3", bus.allocVector, bus.allocValid, rr(0), exp);
    end
    clear_req();
  endtask

  task automatic test_all_distinct();
    logic [35:0] exp;
    do_reset();
    exp = '0;
    for (int i = 0; i < 6; i++) begin
      set_req(i, (i + 1) % 6, 1'b1);
      exp[i*6 + (i + 1) % 6] = 1'b1;
    end
    step();
    tests_run++;
    if (bus.allocVector !== exp || bus.grant !== 6'b111111 || bus.allocValid !== 1'b1) begin
      tests_failed++; $display("FAIL all_distinct: alloc %h grant %b valid %b want %h 111111 1", bus.allocVector, bus.grant, bus.allocValid, exp);
    end
    clear_req();
  endtask

  task automatic test_back_to_back();
    logic [35:0] exp;
    do_reset();
    // Three inputs contend for output 5 on consecutive cycles.
    set_req(0, 5, 1'b1);
    set_req(2, 5, 1'b1);
    set_req(4, 5, 1'b1);
    step();
    exp = '0; exp[0*6+5] = 1'b1;
    tests_run++;
    if (bus.allocVector !== exp) begin
      tests_failed++; $display("FAIL b2b_0: got %h want %h", bus.allocVector, exp);
    end
    step();
    exp = '0; exp[2*6+5] = 1'b1;
    tests_run++;
    if (bus.allocVector !== exp) begin
      tests_failed++; $display("FAIL b2b_1: got %h want %h", bus.allocVector, exp);
    end
    step();
    exp = '0; exp[4*6+5] = 1'b1;
    tests_run++;
    if (bus.allocVector !== exp || rr(5) !== 3'd5) begin
      tests_failed++; $display("FAIL b2b_2: alloc %h rr %0d want %h 5", bus.allocVector, rr(5), exp);
    end
    clear_req();
  endtask

  task automatic test_async_reset();
    do_reset();
    set_req(3, 1, 1'b1);
    step();
    tests_run++;
    if (bus.grant !== 6'b001000) begin
      tests_failed++; $display("FAIL async_pre: got %b want 001000", bus.grant);
    end
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if (bus.grant !== 6'b0 || bus.allocVector !== 36'b0 || bus.allocValid !== 1'b0 || bus.dbgRrPtr !== 18'b0) begin
      tests_failed++; $display("FAIL async_clear: grant %b alloc %h valid %b rr %h want all 0", bus.grant, bus.allocVector, bus.allocValid, bus.dbgRrPtr);
    end
    clear_req();
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

`ifdef ALLOC_LOCK_EN
  task automatic test_lock();
    logic [35:0] exp1;
    logic [35:0] exp4;
    do_reset();
    exp1 = '0; exp1[1*6+3] = 1'b1;
    exp4 = '0; exp4[4*6+3] = 1'b1;
    set_req(1, 3, 1'b0);
    set_req(4, 3, 1'b1);
    step();
    tests_run++;
    if (bus.allocVector !== exp1 || bus.dbgLocked[3] !== 1'b1 || rr(3) !== 3'd2) begin
      tests_failed++; $display("FAIL lock_head: alloc %h lock %b rr %0d want %h 1 2", bus.allocVector, bus.dbgLocked[3], rr(3), exp1);
    end
    for (int c = 0; c < 2; c++) begin
      step();
      tests_run++;
      if (bus.allocVector !== exp1 || rr(3) !== 3'd2) begin
        tests_failed++; $display("FAIL lock_body%0d: alloc %h rr %0d want %h 2", c, bus.allocVector, rr(3), exp1);
      end
    end
    // Owner drops valid: lock retained, nobody granted.
    bus.reqValid[1] = 1'b0;
    step();
    tests_run++;
    if (bus.grant !== 6'b0 || bus.dbgLocked[3] !== 1'b1) begin
      tests_failed++; $display("FAIL lock_gap: grant %b lock %b want 000000 1", bus.grant, bus.dbgLocked[3]);
    end
    set_req(1, 3, 1'b1);
    step();
    tests_run++;
    if (bus.allocVector !== exp1 || bus.dbgLocked[3] !== 1'b0 || rr(3) !== 3'd2) begin
      tests_failed++; $display("FAIL lock_tail: alloc %h lock %b rr %0d want %h 0 2", bus.allocVector, bus.dbgLocked[3], rr(3), exp1);
    end
    bus.reqValid[1] = 1'b0;
    step();
    tests_run++;
    if (bus.allocVector !== exp4 || rr(3) !== 3'd5) begin
      tests_failed++; $display("FAIL lock_next: alloc %h rr %0d want %h 5", bus.allocVector, rr(3), exp4);
    end
    clear_req();
  endtask

  task automatic test_lock_reset();
    logic [35:0] exp4;
    do_reset();
    exp4 = '0; exp4[4*6+3] = 1'b1;
    set_req(1, 3, 1'b0);
    step();
    tests_run++;
    if (bus.dbgLocked[3] !== 1'b1) begin
      tests_failed++; $display("FAIL lrst_locked: got %b want 1", bus.dbgLocked[3]);
    end
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if (bus.grant !== 6'b0 || bus.allocValid !== 1'b0 || bus.dbgLocked !== 6'b0) begin
      tests_failed++; $display("FAIL lrst_clear: grant %b valid %b lock %b want 0 0 0", bus.grant, bus.allocValid, bus.dbgLocked);
    end
    clear_req();
    @(negedge clk);
    reset = 1'b0;
    set_req(4, 3, 1'b1);
    step();
    tests_run++;
    if (bus.allocVector !== exp4 || bus.grant !== 6'b010000) begin
      tests_failed++; $display("FAIL lrst_fresh: alloc %h grant %b want %h 010000", bus.allocVector, bus.grant, exp4);
    end
    clear_req();
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    clear_req();
    bus.outReady = '1;
    test_reset();
    test_round_robin();
    test_wrap();
    test_blocked();
    test_all_distinct();
    test_back_to_back();
    test_async_reset();
`ifdef ALLOC_LOCK_EN
    test_lock();
    test_lock_reset();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
